fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of decode/execute. Holds the program counter and issues one instruction-memory request at a time over a req/ack handshake. Fetched {pc, instr} pairs are buffered in a small FIFO and presented to decode with valid/ready. Consumes the execute stage's branch redirect (exeOverride plus 16-bit word offset exeData) and flushes wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, number of buffered fetched instructions (power of 2, min 2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imemReq  out  1  request to instruction memory
imemAddr  out  32  byte address of requested word
imemAck  in  1  memory accepted request; imemData valid this cycle
imemData  in  32  returned instruction word
instrValid  out  1  instr/instrPc valid for decode
instr  out  32  instruction at FIFO head
instrPc  out  32  byte PC of instr
decodeReady  in  1  decode accepts head this cycle
redirectValid  in  1  branch taken (execute exeOverride)
redirectOffset  in  16  signed word offset (execute exeData)
redirectBasePc  in  32  PC of the taken branch
flushOut  out  1  registered pulse, high one cycle after a redirect is applied

Behaviour:
- Reset (async, any time, including mid-request): pc=RESET_PC; FIFO empty; state IDLE; imemReq=0, imemAddr=0, instrValid=0, instr=0, instrPc=0, flushOut=0. Any in-flight memory response is forgotten; memory must tolerate a dropped request.
- States: IDLE, FETCH, DISCARD.
- IDLE: one cycle after reset release, then FETCH. No request is issued.
- FETCH, issue rule: assert imemReq with imemAddr=pc only when FIFO count < FIFO_DEPTH. Once asserted, req and addr stay stable until imemAck is sampled high. Ack may arrive in the first req cycle (zero-wait).
- FETCH, on ack: push {pc, imemData}, pc <= pc+4 (wraps mod 2^32). Req may re-assert the next cycle if space remains. Throughput: 1 instr/cycle with zero-wait memory and a ready decode.
- Output: instrValid = (count != 0); instr/instrPc = FIFO head. Pop when instrValid && decodeReady. Push and pop in the same cycle keep count unchanged. Push at full cannot occur, because issue is gated on space.
- Redirect target = redirectBasePc + {{14{redirectOffset[15]}}, redirectOffset, 2'b00}, mod 2^32.
- Redirect applied on the clock edge where redirectValid=1. It has priority over push and pop that cycle:
  - FIFO count <= 0, so instrValid=0 next cycle. A simultaneous pop is ignored.
  - pc <= target; flushOut=1 for the next cycle.
  - If imemReq is high and imemAck is low: go to DISCARD.
  - If imemAck is high that cycle: the response is dropped (not pushed) and the state stays FETCH at target.
  - If no request is outstanding: stay FETCH.
- DISCARD: hold imemReq and the old imemAddr until ack. On ack, drop the data and go to FETCH, which issues target the next cycle.
- Redirect during DISCARD: pc <= new target; stay in DISCARD.
- redirectValid held for multiple cycles: each cycle is a new redirect, and the last one wins.
- No combinational path from imemData/imemAck to imemReq. instrValid/instr/instrPc come from registers only.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE/FETCH/DISCARD)
  - INSTR_W=32, PC_INC=4, RESET_PC default
  - redirect target function (sign-extend, shift 2, add)
- One sub-module: fetch_fifo. FIFO_DEPTH-entry {pc, instr} circular buffer with push, pop, flush, count, head outputs, and async active-high reset. Flush has priority over push/pop.

Test Plan:
- Reset release with RESET_PC=0, zero-wait ack, decodeReady=1 -> first req at addr 0x0, then instrPc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, each paired with the returned word.
- decodeReady=0 from the start -> exactly 2 acks accepted (pc 0x0, 0x4). imemReq stays low while count=2. After 1 cycle of ready, one new req goes out at 0x8.
- Redirect with base 0x20, offset 16'hFFFC (-4 words) and no request outstanding -> next issued addr 0x10, instrValid=0 for ≥1 cycle, flushOut one-cycle pulse.
- Redirect while req pending at 0x14 with ack delayed 3 cycles -> imemAddr stays 0x14 until ack, data discarded (never appears on instr), next req at target 0x40 (base 0x30, offset 4).
- Redirect coincident with ack at 0x8 -> word for 0x8 never presented. Coincident pop ignored, FIFO empty. Next req at target.
- Async rst asserted mid-request, not on a clock edge -> imemReq and instrValid drop immediately. After release: IDLE for 1 cycle, then req at RESET_PC. pc=0xFFFF_FFFC followed by ack -> next addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DISCARD
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Branch target: word offset is sign-extended and scaled to bytes.
  function automatic logic [31:0] redirect_target(input logic [31:0] base_pc,
                                                  input logic [15:0] word_offset);
    return base_pc + {{14{word_offset[15]}}, word_offset, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} pairs; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is reset because the head drives decode directly and must
  // read as zero out of reset; at this depth the cost is a handful of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, buffered output
// to decode, and branch redirect with wrong-path discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        decodeReady,
  input  logic        redirectValid,
  input  logic [15:0] redirectOffset,
  input  logic [31:0] redirectBasePc,
  output logic        flushOut
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      hold_addr_q, hold_addr_d;
  logic             flush_q;
  logic [CNT_W-1:0] count;
  logic             has_space, push, pop;
  fetch_entry_t     head, push_data;

  assign has_space = count < CNT_W'(FIFO_DEPTH);
  assign push_data = '{pc: pc_q, instr: imemData};
  assign pop       = instrValid && decodeReady && !redirectValid;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    imemReq     = 1'b0;
    imemAddr    = '0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imemReq  = has_space;
        imemAddr = has_space ? pc_q : '0;
        if (redirectValid) begin
          // An unanswered request must still be drained; remember its address.
          if (imemReq && !imemAck) begin
            state_d     = ST_DISCARD;
            hold_addr_d = pc_q;
          end
        end else if (imemReq && imemAck) begin
          push = 1'b1;
          pc_d = pc_q + PC_INC;
        end
      end
      ST_DISCARD: begin
        imemReq  = 1'b1;
        imemAddr = hold_addr_q;
        if (imemAck && !redirectValid) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirectValid) pc_d = redirect_target(redirectBasePc, redirectOffset);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      hold_addr_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      flush_q     <= redirectValid;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirectValid),
    .data_i  (push_data),
    .head_o  (head),
    .count_o (count)
  );

  assign instrValid = (count != '0);
  assign instr      = head.instr;
  assign instrPc    = head.pc;
  assign flushOut   = flush_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a program-order stream model.
module tb_fetch_unit;

  logic        clk, rst;
  logic        imemReq, imemAck;
  logic [31:0] imemAddr, imemData;
  logic        instrValid, decodeReady;
  logic [31:0] instr, instrPc;
  logic        redirectValid;
  logic [15:0] redirectOffset;
  logic [31:0] redirectBasePc;
  logic        flushOut;

  int n_checks = 0;
  int n_errors = 0;

  int mem_cnt, mem_lat;
  bit rnd_lat;

  logic        pre_req, pre_ack, pre_valid, pre_ready, pre_redirect;
  logic [31:0] pre_addr, pre_pc, pre_instr, pre_base;
  logic [15:0] pre_off;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemAck        (imemAck),
    .imemData       (imemData),
    .instrValid     (instrValid),
    .instr          (instr),
    .instrPc        (instrPc),
    .decodeReady    (decodeReady),
    .redirectValid  (redirectValid),
    .redirectOffset (redirectOffset),
    .redirectBasePc (redirectBasePc),
    .flushOut       (flushOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] b, input logic [15:0] o);
    int w;
    w = $signed(o);
    return b + 32'(w * 4);
  endfunction

  // One clock: memory responds after mem_lat waiting cycles, pre-edge state is recorded.
  task automatic cycle();
    imemAck      = imemReq && (mem_cnt >= mem_lat);
    imemData     = imemAck ? mem_word(imemAddr) : 32'hDEAD_BEEF;
    pre_req      = imemReq;
    pre_addr     = imemAddr;
    pre_ack      = imemAck;
    pre_valid    = instrValid;
    pre_pc       = instrPc;
    pre_instr    = instr;
    pre_ready    = decodeReady;
    pre_redirect = redirectValid;
    pre_base     = redirectBasePc;
    pre_off      = redirectOffset;
    @(posedge clk);
    #1;
    if (!pre_req || pre_ack) mem_cnt = 0;
    else mem_cnt++;
    if (pre_ack && rnd_lat) mem_lat = $urandom_range(0, 3);
    imemAck = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    decodeReady = 1'b0; redirectValid = 1'b0; redirectOffset = '0; redirectBasePc = '0;
    imemAck = 1'b0; imemData = '0;
    mem_cnt = 0; mem_lat = 0; rnd_lat = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    decodeReady = 1'b0; redirectValid = 1'b0; redirectOffset = '0; redirectBasePc = '0;
    imemAck = 1'b0; imemData = '0; mem_cnt = 0; mem_lat = 0; rnd_lat = 1'b0;
    #7;
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", imemReq); end
    n_checks++; if (imemAddr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", imemAddr); end
    n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", instrValid); end
    n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    n_checks++; if (instrPc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected 0", instrPc); end
    n_checks++; if (flushOut !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %b expected 0", flushOut); end
    rst = 1'b0;
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL idle_req: got %b expected 0", imemReq); end
    cycle();
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      n_errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imemReq, imemAddr); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    decodeReady = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'(4 * k)) begin
        n_errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, imemReq, imemAddr, 32'(4 * k)); end
      if (k >= 1) begin
        e = 32'(4 * (k - 1));
        n_checks++; if (instrValid !== 1'b1 || instrPc !== e || instr !== mem_word(e)) begin
          n_errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                               k, instrValid, instrPc, instr, e, mem_word(e)); end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    int acks;
    do_reset();
    decodeReady = 1'b0;
    cycle();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (pre_req && pre_ack) acks++;
    end
    n_checks++; if (acks != 2) begin n_errors++; $display("FAIL bp_acks: got %0d expected 2", acks); end
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL bp_req_full: got %b expected 0", imemReq); end
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
      n_errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", instrValid, instrPc); end
    decodeReady = 1'b1;
    cycle();
    decodeReady = 1'b0;
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
      n_errors++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=8", imemReq, imemAddr); end
    n_checks++; if (instrPc !== 32'h4) begin n_errors++; $display("FAIL bp_head2: got %h expected 4", instrPc); end
  endtask

  task automatic test_redirect_idle();
    do_reset();
    decodeReady = 1'b0;
    repeat (4) cycle();
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL ri_pre_req: got %b expected 0", imemReq); end
    redirectValid = 1'b1; redirectBasePc = 32'h20; redirectOffset = 16'hFFFC; decodeReady = 1'b1;
    cycle();
    redirectValid = 1'b0;
    n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL ri_valid: got %b expected 0", instrValid); end
    n_checks++; if (flushOut !== 1'b1) begin n_errors++; $display("FAIL ri_flush: got %b expected 1", flushOut); end
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin
      n_errors++; $display("FAIL ri_addr: got req=%b addr=%h expected req=1 addr=10", imemReq, imemAddr); end
    cycle();
    n_checks++; if (flushOut !== 1'b0) begin n_errors++; $display("FAIL ri_flush_pulse: got %b expected 0", flushOut); end
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h10 || instr !== mem_word(32'h10)) begin
      n_errors++; $display("FAIL ri_out: got v=%b pc=%h instr=%h expected v=1 pc=10 instr=%h",
                           instrValid, instrPc, instr, mem_word(32'h10)); end
  endtask

  task automatic test_redirect_pending();
    bit found;
    do_reset();
    decodeReady = 1'b1;
    cycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imemReq === 1'b1 && imemAddr === 32'h14) found = 1'b1;
      else cycle();
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL rp_reach: got no request at 14 expected one within 20 cycles"); end
    mem_lat = 3;
    redirectValid = 1'b1; redirectBasePc = 32'h30; redirectOffset = 16'h0004;
    cycle();
    redirectValid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14) begin
        n_errors++; $display("FAIL rp_hold[%0d]: got req=%b addr=%h expected req=1 addr=14", j, imemReq, imemAddr); end
      n_checks++; if (instrValid !== 1'b0) begin
        n_errors++; $display("FAIL rp_valid[%0d]: got %b expected 0", j, instrValid); end
      cycle();
    end
    mem_lat = 0;
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
      n_errors++; $display("FAIL rp_target: got req=%b addr=%h expected req=1 addr=40", imemReq, imemAddr); end
    n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL rp_dropped: got valid=%b pc=%h expected 0", instrValid, instrPc); end
    cycle();
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h40 || instr !== mem_word(32'h40)) begin
      n_errors++; $display("FAIL rp_out: got v=%b pc=%h instr=%h expected v=1 pc=40 instr=%h",
                           instrValid, instrPc, instr, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    decodeReady = 1'b1;
    repeat (3) cycle();
    n_checks++; if (imemAddr !== 32'h8 || instrValid !== 1'b1) begin
      n_errors++; $display("FAIL ra_pre: got addr=%h v=%b expected addr=8 v=1", imemAddr, instrValid); end
    redirectValid = 1'b1; redirectBasePc = 32'h100; redirectOffset = 16'h0008;
    cycle();
    redirectValid = 1'b0;
    n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL ra_valid: got %b expected 0", instrValid); end
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h120) begin
      n_errors++; $display("FAIL ra_target: got req=%b addr=%h expected req=1 addr=120", imemReq, imemAddr); end
    n_checks++; if (flushOut !== 1'b1) begin n_errors++; $display("FAIL ra_flush: got %b expected 1", flushOut); end
    cycle();
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h120 || instr !== mem_word(32'h120)) begin
      n_errors++; $display("FAIL ra_out: got v=%b pc=%h instr=%h expected v=1 pc=120 instr=%h",
                           instrValid, instrPc, instr, mem_word(32'h120)); end
  endtask

  task automatic test_async_reset_wrap();
    do_reset();
    decodeReady = 1'b0;
    repeat (2) cycle();
    mem_lat = 10;
    cycle();
    n_checks++; if (imemReq !== 1'b1 || instrValid !== 1'b1) begin
      n_errors++; $display("FAIL ar_pre: got req=%b v=%b expected req=1 v=1", imemReq, instrValid); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL ar_req: got %b expected 0", imemReq); end
    n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL ar_valid: got %b expected 0", instrValid); end
    #2 rst = 1'b0;
    mem_cnt = 0; mem_lat = 0;
    n_checks++; if (imemReq !== 1'b0) begin n_errors++; $display("FAIL ar_idle: got %b expected 0", imemReq); end
    cycle();
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      n_errors++; $display("FAIL ar_restart: got req=%b addr=%h expected req=1 addr=0", imemReq, imemAddr); end
    redirectValid = 1'b1; redirectBasePc = 32'hFFFF_FFFC; redirectOffset = 16'h0000;
    cycle();
    redirectValid = 1'b0;
    decodeReady = 1'b1;
    n_checks++; if (imemAddr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_pre: got %h expected fffffffc", imemAddr); end
    cycle();
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      n_errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=0", imemReq, imemAddr); end
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_out: got v=%b pc=%h expected v=1 pc=fffffffc", instrValid, instrPc); end
  endtask

  // Decode must see a contiguous +4 stream that restarts at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    int pops;
    do_reset();
    rnd_lat = 1'b1;
    mem_lat = $urandom_range(0, 3);
    exp_pc = 32'h0;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      decodeReady    = ($urandom_range(0, 3) != 0);
      redirectValid  = ($urandom_range(0, 15) == 0);
      redirectBasePc = $urandom;
      redirectOffset = 16'($urandom);
      cycle();
      if (pre_valid) begin
        n_checks++; if (pre_pc !== exp_pc || pre_instr !== mem_word(exp_pc)) begin
          n_errors++; $display("FAIL rnd_head@%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                               i, pre_pc, pre_instr, exp_pc, mem_word(exp_pc)); end
      end
      if (pre_redirect) begin
        exp_pc = model_target(pre_base, pre_off);
        n_checks++; if (instrValid !== 1'b0 || flushOut !== 1'b1) begin
          n_errors++; $display("FAIL rnd_redirect@%0d: got v=%b flush=%b expected v=0 flush=1", i, instrValid, flushOut); end
      end else begin
        n_checks++; if (flushOut !== 1'b0) begin
          n_errors++; $display("FAIL rnd_flush@%0d: got %b expected 0", i, flushOut); end
        if (pre_valid && pre_ready) begin
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
      if (pre_req && !pre_ack) begin
        n_checks++; if (imemReq !== 1'b1 || imemAddr !== pre_addr) begin
          n_errors++; $display("FAIL rnd_stable@%0d: got req=%b addr=%h expected req=1 addr=%h", i, imemReq, imemAddr, pre_addr); end
      end
    end
    redirectValid = 1'b0;
    n_checks++; if (pops < 200) begin n_errors++; $display("FAIL rnd_progress: got %0d pops expected at least 200", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_idle();
    test_redirect_pending();
    test_redirect_ack();
    test_async_reset_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
